vsc8541_smi_responder: RTL and testbench

PHY-side (responder) end of the IEEE 802.3 Clause 22 SMI/MDIO management interface. The block oversamples an incoming MDC/MDIO pair on the system clock, decodes read and write frames addressed to its PHY address, and drives read data back on MDIO. It sits between the board MDIO pins (or a simulated SMI master) and a 32×16 register file. It serves as the register-access front end of a VSC8541 PHY model and as a loopback target for the SMI master path.

---
 rtl/vsc8541_smi_pkg.sv | 29 ++
 rtl/counter.sv | 35 +++
 rtl/vsc8541_smi_sync_edge.sv | 49 ++++
 rtl/vsc8541_smi_responder.sv | 253 +++++++++++++++++++++++++
 tb/tb_vsc8541_smi_responder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/vsc8541_smi_pkg.sv
// Shared SMI (Clause 22 MDIO) definitions for the VSC8541 responder and master.
package vsc8541_smi_pkg;

    // OP field encodings on the wire
    typedef enum logic [1:0] {
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10
    } smi_op_t;

    // Responder frame-decode states
    typedef enum logic [2:0] {
        S_HUNT,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA,
        S_SKIP
    } smi_state_t;

    localparam logic [1:0] SMI_ST_CODE = 2'b01;
    localparam int SMI_OP_W    = 2;
    localparam int SMI_PHYAD_W = 5;
    localparam int SMI_REGAD_W = 5;
    localparam int SMI_TA_W    = 2;
    localparam int SMI_DATA_W  = 16;

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear (priority) and count enable.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q, count_d;

    // Clear wins over enable; count wraps naturally.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/vsc8541_smi_sync_edge.sv
// Two-flop synchronizer with registered rise/fall pulses for one async input.
module vsc8541_smi_sync_edge (
    input  logic clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Next-state for the synchronizer chain and the edge detector.
    // NOTE: every _d is assigned on every path of an always_comb, otherwise a latch is inferred.
    always_comb begin
        meta_d = i_async;
        sync_d = meta_q;
        prev_d = sync_q;
        rise_d = sync_q & ~prev_q;
        fall_d = ~sync_q & prev_q;
    end

    // Register chain; edge pulses are registered so input-to-pulse latency is 3 clk.
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_level = sync_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/vsc8541_smi_responder.sv
// PHY-side Clause 22 SMI responder: oversamples MDC/MDIO, decodes frames for
// PHY_ADDR, strobes a 32x16 register file and serialises read data on MDIO.
module vsc8541_smi_responder
    import vsc8541_smi_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR     = 5'd0,
    parameter int         PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_mdc,
    input  logic        i_mdio,
    output logic        o_mdio,
    output logic        o_mdio_oe,
    output logic [4:0]  o_reg_addr,
    output logic        o_reg_re,
    input  logic [15:0] i_reg_rdata,
    output logic [15:0] o_reg_wdata,
    output logic        o_reg_we,
    output logic        o_frame_err,
    output logic        o_busy
);

    localparam logic [5:0] PRE_LEN    = 6'(PREAMBLE_LEN);
    localparam logic [5:0] ONES_MAX   = 6'd32;
    localparam logic [4:0] OP_LAST    = 5'(SMI_OP_W - 1);
    localparam logic [4:0] PHYAD_LAST = 5'(SMI_PHYAD_W - 1);
    localparam logic [4:0] REGAD_LAST = 5'(SMI_REGAD_W - 1);
    localparam logic [4:0] TA_LAST    = 5'(SMI_TA_W - 1);
    localparam logic [4:0] DATA_LAST  = 5'(SMI_DATA_W - 1);
    localparam logic [4:0] SKIP_LAST  = 5'(SMI_REGAD_W + SMI_TA_W + SMI_DATA_W - 1);

    // Conditioned inputs
    logic mdc_rise, mdc_level, mdc_fall;
    logic mdio_s, mdio_rise, mdio_fall;
    logic unused_sync;

    vsc8541_smi_sync_edge u_sync_mdc (
        .clk     (clk),
        .i_reset (i_reset),
        .i_async (i_mdc),
        .o_level (mdc_level),
        .o_rise  (mdc_rise),
        .o_fall  (mdc_fall)
    );

    vsc8541_smi_sync_edge u_sync_mdio (
        .clk     (clk),
        .i_reset (i_reset),
        .i_async (i_mdio),
        .o_level (mdio_s),
        .o_rise  (mdio_rise),
        .o_fall  (mdio_fall)
    );

    assign unused_sync = ^{mdc_level, mdc_fall, mdio_rise, mdio_fall};

    // Field bit counter, advanced on every sampled MDC edge
    logic [4:0] bit_cnt;
    logic       bit_clear;

    counter #(.WIDTH(5)) u_bit_cnt (
        .clk     (clk),
        .i_reset (i_reset),
        .i_clear (bit_clear),
        .i_en    (mdc_rise),
        .o_count (bit_cnt)
    );

    smi_state_t  state_q, state_d;
    logic [5:0]  ones_q, ones_d;
    logic        is_read_q, is_read_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        mdio_q, mdio_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic        reg_re_q, reg_re_d;
    logic        reg_we_q, reg_we_d;
    logic        frame_err_q, frame_err_d;
    logic        busy_q, busy_d;
    logic        capture_q, capture_d;

    logic [1:0] op_bits;
    logic [4:0] phy_bits;

    assign op_bits  = {shift_q[0], mdio_s};
    assign phy_bits = {shift_q[3:0], mdio_s};

    // Frame decode: next state, shift datapath, strobes and MDIO drive.
    always_comb begin
        state_d     = state_q;
        ones_d      = ones_q;
        is_read_d   = is_read_q;
        shift_d     = shift_q;
        reg_addr_d  = reg_addr_q;
        wdata_d     = wdata_q;
        mdio_d      = mdio_q;
        mdio_oe_d   = mdio_oe_q;
        reg_re_d    = 1'b0;
        reg_we_d    = 1'b0;
        frame_err_d = 1'b0;
        capture_d   = reg_re_q;

        // Register file answers one clk after the read strobe.
        if (capture_q) begin
            shift_d = i_reg_rdata;
        end

        if (mdc_rise) begin
            unique case (state_q)
                S_HUNT: begin
                    if (mdio_s) begin
                        if (ones_q != ONES_MAX) begin
                            ones_d = ones_q + 6'd1;
                        end
                    end else begin
                        // A 0 after a full preamble is the first ST bit.
                        ones_d = '0;
                        if (ones_q >= PRE_LEN) begin
                            state_d = S_ST;
                        end
                    end
                end
                S_ST: begin
                    if (mdio_s == SMI_ST_CODE[0]) begin
                        state_d = S_OP;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_HUNT;
                    end
                end
                S_OP: begin
                    shift_d = {shift_q[14:0], mdio_s};
                    if (bit_cnt == OP_LAST) begin
                        if (op_bits == OP_READ) begin
                            is_read_d = 1'b1;
                            state_d   = S_PHYAD;
                        end else if (op_bits == OP_WRITE) begin
                            is_read_d = 1'b0;
                            state_d   = S_PHYAD;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_HUNT;
                        end
                    end
                end
                S_PHYAD: begin
                    shift_d = {shift_q[14:0], mdio_s};
                    if (bit_cnt == PHYAD_LAST) begin
                        state_d = (phy_bits == PHY_ADDR) ? S_REGAD : S_SKIP;
                    end
                end
                S_REGAD: begin
                    reg_addr_d = {reg_addr_q[3:0], mdio_s};
                    if (bit_cnt == REGAD_LAST) begin
                        reg_re_d = is_read_q;
                        state_d  = S_TA;
                    end
                end
                S_TA: begin
                    if (is_read_q) begin
                        if (bit_cnt == 5'd0) begin
                            // Take the line and drive the TA zero.
                            mdio_oe_d = 1'b1;
                            mdio_d    = 1'b0;
                        end else begin
                            mdio_d  = shift_q[15];
                            shift_d = {shift_q[14:0], 1'b0};
                        end
                    end
                    if (bit_cnt == TA_LAST) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (is_read_q) begin
                        if (bit_cnt == DATA_LAST) begin
                            // D0 has been sampled by the master: release.
                            mdio_oe_d = 1'b0;
                            mdio_d    = 1'b1;
                            state_d   = S_HUNT;
                        end else begin
                            mdio_d  = shift_q[15];
                            shift_d = {shift_q[14:0], 1'b0};
                        end
                    end else begin
                        shift_d = {shift_q[14:0], mdio_s};
                        if (bit_cnt == DATA_LAST) begin
                            wdata_d  = {shift_q[14:0], mdio_s};
                            reg_we_d = 1'b1;
                            state_d  = S_HUNT;
                        end
                    end
                end
                S_SKIP: begin
                    if (bit_cnt == SKIP_LAST) begin
                        state_d = S_HUNT;
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end
    end

    // Bit counter restarts at each field boundary and idles at 0 while hunting.
    assign bit_clear = mdc_rise && ((state_d != state_q) || (state_q == S_HUNT));
    assign busy_d    = (state_d != S_HUNT);

    // State and datapath registers.
    // NOTE: the shift datapath is reset along with control so a reset mid-read can never replay stale data.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q     <= S_HUNT;
            ones_q      <= '0;
            is_read_q   <= 1'b0;
            shift_q     <= '0;
            reg_addr_q  <= '0;
            wdata_q     <= '0;
            mdio_q      <= 1'b1;
            mdio_oe_q   <= 1'b0;
            reg_re_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            capture_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_q      <= ones_d;
            is_read_q   <= is_read_d;
            shift_q     <= shift_d;
            reg_addr_q  <= reg_addr_d;
            wdata_q     <= wdata_d;
            mdio_q      <= mdio_d;
            mdio_oe_q   <= mdio_oe_d;
            reg_re_q    <= reg_re_d;
            reg_we_q    <= reg_we_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            capture_q   <= capture_d;
        end
    end

    assign o_mdio      = mdio_q;
    assign o_mdio_oe   = mdio_oe_q;
    assign o_reg_addr  = reg_addr_q;
    assign o_reg_re    = reg_re_q;
    assign o_reg_wdata = wdata_q;
    assign o_reg_we    = reg_we_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_vsc8541_smi_responder.sv
// Self-checking bench: an SMI master drives directed and random frames; a
// frame-level reference model predicts strobes, errors and read data.
module tb_vsc8541_smi_responder;

    localparam int         HALF = 5;      // clk per MDC phase
    localparam logic [4:0] PHY  = 5'd0;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_mdc;
    wire         i_mdio;
    logic        o_mdio, o_mdio_oe;
    logic [4:0]  o_reg_addr;
    logic        o_reg_re, o_reg_we, o_frame_err, o_busy;
    logic [15:0] o_reg_wdata;
    logic [15:0] rf_rdata = 16'h0;

    // Master side of the bus, with pull-up when nobody drives
    logic m_oe, m_bit;
    wire  mdio_line = o_mdio_oe ? o_mdio : (m_oe ? m_bit : 1'b1);
    assign i_mdio = mdio_line;

    always #5 clk = ~clk;

    vsc8541_smi_responder #(.PHY_ADDR(PHY), .PREAMBLE_LEN(32)) dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_mdc       (i_mdc),
        .i_mdio      (i_mdio),
        .o_mdio      (o_mdio),
        .o_mdio_oe   (o_mdio_oe),
        .o_reg_addr  (o_reg_addr),
        .o_reg_re    (o_reg_re),
        .i_reg_rdata (rf_rdata),
        .o_reg_wdata (o_reg_wdata),
        .o_reg_we    (o_reg_we),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    // Registered register file attached to the responder
    logic [15:0] rf [32];
    always @(posedge clk) begin
        if (o_reg_we) rf[o_reg_addr] <= o_reg_wdata;
        if (o_reg_re) rf_rdata <= rf[o_reg_addr];
    end

    // Reference contents: what each register should hold given the frames sent
    logic [15:0] model_mem [32];

    // Event monitors, sampled away from the active edge
    int          we_cnt = 0, re_cnt = 0, err_cnt = 0, oe_cnt = 0, clash_cnt = 0;
    logic [4:0]  we_addr = 5'd0;
    logic [15:0] we_data = 16'd0;
    always @(negedge clk) begin
        if (o_reg_we) begin
            we_cnt++;
            we_addr = o_reg_addr;
            we_data = o_reg_wdata;
        end
        if (o_reg_re)    re_cnt++;
        if (o_frame_err) err_cnt++;
        if (o_mdio_oe)   oe_cnt++;
        if (o_mdio_oe && m_oe) clash_cnt++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One MDC period: data set in the low phase, line sampled at the rising edge
    task automatic mdc_bit(input logic drv, input logic val, output logic smp);
        i_mdc = 1'b0;
        m_oe  = drv;
        m_bit = val;
        repeat (HALF) @(negedge clk);
        smp   = mdio_line;
        i_mdc = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Idle zero, preamble, then the 32-bit frame; optional reset after bit rst_bit
    task automatic send_frame(input int pre, input logic [31:0] fr, input logic is_rd_op,
                              input int rst_bit, output logic [17:0] rd_bits, output logic busy_mid);
        logic smp;
        rd_bits  = '0;
        busy_mid = 1'b0;
        mdc_bit(1'b1, 1'b0, smp);
        for (int i = 0; i < pre; i++) mdc_bit(1'b1, 1'b1, smp);
        for (int i = 0; i < 32; i++) begin
            mdc_bit(!(is_rd_op && i >= 14), fr[31-i], smp);
            if (i >= 14) rd_bits = {rd_bits[16:0], smp};
            if (i == 12) busy_mid = o_busy;
            if (i == rst_bit) begin
                check("oe_before_reset", o_mdio_oe, 1'b1);
                i_reset = 1'b1;
                @(negedge clk);
                check("oe_after_reset", o_mdio_oe, 1'b0);
                i_reset = 1'b0;
            end
        end
    endtask

    // Predict a frame's effect from its fields, send it, compare
    task automatic run_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                             input logic [4:0] phy, input logic [4:0] reg_a,
                             input logic [15:0] data, input int rst_bit);
        int          we0, re0, err0, oe0, clash0;
        logic [17:0] rd;
        logic        bm;
        logic        pre_ok, st_ok, op_ok, hit, exp_rd, exp_wr, exp_err, exp_busy;
        logic [17:0] exp_bits;
        pre_ok   = (pre >= 32);
        st_ok    = (st == 2'b01);
        op_ok    = (op == 2'b10) || (op == 2'b01);
        hit      = (phy == PHY);
        exp_err  = pre_ok && (!st_ok || !op_ok);
        exp_busy = pre_ok && st_ok && op_ok;
        exp_rd   = exp_busy && hit && (op == 2'b10);
        exp_wr   = exp_busy && hit && (op == 2'b01) && (rst_bit < 0);
        exp_bits = {2'b10, model_mem[reg_a]};
        we0 = we_cnt; re0 = re_cnt; err0 = err_cnt; oe0 = oe_cnt; clash0 = clash_cnt;

        send_frame(pre, {st, op, phy, reg_a, 2'b10, data}, (op == 2'b10), rst_bit, rd, bm);

        check("we_pulses",  32'(we_cnt - we0),   32'(exp_wr));
        check("re_pulses",  32'(re_cnt - re0),   32'(exp_rd));
        check("err_pulses", 32'(err_cnt - err0), 32'(exp_err));
        check("oe_seen",    32'(oe_cnt != oe0),  32'(exp_rd));
        check("bus_clash",  32'(clash_cnt - clash0), 32'd0);
        check("busy_mid",   bm, exp_busy);
        check("oe_end",     o_mdio_oe, 1'b0);
        check("busy_end",   o_busy, 1'b0);
        if (exp_wr) begin
            check("we_addr", we_addr, reg_a);
            check("we_data", we_data, data);
            model_mem[reg_a] = data;
        end
        if (exp_rd && rst_bit < 0) check("read_bits", rd, exp_bits);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        int          r, pre;
        logic [1:0]  st, op;
        logic [4:0]  phy, reg_a;
        logic [15:0] data;

        for (int i = 0; i < 32; i++) begin
            v = 16'($urandom);
            rf[i] = v;
            model_mem[i] = v;
        end
        rf[2] = 16'hBEEF;
        model_mem[2] = 16'hBEEF;

        i_reset = 1'b1;
        i_mdc   = 1'b0;
        m_oe    = 1'b1;
        m_bit   = 1'b1;
        repeat (4) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        check("rst_mdio",      o_mdio,      1'b1);
        check("rst_mdio_oe",   o_mdio_oe,   1'b0);
        check("rst_reg_addr",  o_reg_addr,  5'd0);
        check("rst_reg_wdata", o_reg_wdata, 16'd0);
        check("rst_reg_re",    o_reg_re,    1'b0);
        check("rst_reg_we",    o_reg_we,    1'b0);
        check("rst_frame_err", o_frame_err, 1'b0);
        check("rst_busy",      o_busy,      1'b0);

        // Directed frames
        run_frame(32, 2'b01, 2'b01, 5'h00, 5'h04, 16'hA5C3, -1);  // write
        run_frame(32, 2'b01, 2'b10, 5'h00, 5'h02, 16'h0000, -1);  // read BEEF
        run_frame(32, 2'b01, 2'b10, 5'h07, 5'h02, 16'h0000, -1);  // other PHY
        run_frame(32, 2'b01, 2'b01, 5'h00, 5'h06, 16'h1234, -1);  // accepted after mismatch
        run_frame(32, 2'b01, 2'b11, 5'h00, 5'h06, 16'hFFFF, -1);  // bad OP 11
        run_frame(32, 2'b01, 2'b00, 5'h00, 5'h06, 16'hFFFF, -1);  // bad OP 00
        run_frame(32, 2'b00, 2'b01, 5'h00, 5'h06, 16'hFFFF, -1);  // bad ST
        run_frame(31, 2'b01, 2'b01, 5'h00, 5'h06, 16'hDEAD, -1);  // short preamble
        run_frame(32, 2'b01, 2'b10, 5'h00, 5'h06, 16'h0000, -1);  // still 1234
        run_frame(32, 2'b01, 2'b10, 5'h00, 5'h02, 16'h0000, 23);  // reset at D8
        run_frame(32, 2'b01, 2'b01, 5'h00, 5'h11, 16'h5A0F, -1);  // write after reset
        run_frame(32, 2'b01, 2'b01, 5'h00, 5'h09, 16'hC0DE, -1);  // back-to-back
        run_frame(32, 2'b01, 2'b10, 5'h00, 5'h09, 16'h0000, -1);

        // Randomised frames
        for (int n = 0; n < 30; n++) begin
            r     = int'($urandom_range(0, 9));
            pre   = 32 + int'($urandom_range(0, 6));
            st    = 2'b01;
            op    = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
            phy   = PHY;
            reg_a = 5'($urandom_range(0, 31));
            data  = 16'($urandom);
            case (r)
                0: phy = 5'($urandom_range(1, 31));
                1: op  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                2: pre = int'($urandom_range(20, 31));
                3: st  = 2'b00;
                default: ;
            endcase
            run_frame(pre, st, op, phy, reg_a, data, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
